// File: rtl/csa_mul_seq_if.sv
// csa_mul_seq_if: operand/result handshake bundle for the carry-save sequential multiplier
interface csa_mul_seq_if #(
    parameter int WIDTH = 8
) ();
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] row_s;
    logic [2*WIDTH-1:0] row_c;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, row_s, row_c
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, row_s, row_c
    );
endinterface

// File: rtl/csa_mul_seq.sv
// csa_mul_seq: one partial product per cycle accumulated in carry-save form;
// the final carry-propagate add is left to the downstream adder.
module csa_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    csa_mul_seq_if.slave bus
);
    localparam int IW = $clog2(WIDTH) + 1;
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b;
    logic [PW-1:0]    r_s, r_c, w_pp;
    logic [IW-1:0]    r_i;
    logic             w_last;

    assign w_last = r_i == IW'(WIDTH - 1);
    assign w_pp   = r_b[r_i[IW-2:0]] ? ({{WIDTH{1'b0}}, r_a} << r_i) : '0;

    assign bus.in_ready  = r_state == IDLE;
    assign bus.out_valid = r_state == DONE;
    assign bus.row_s     = r_s;
    assign bus.row_c     = r_c;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = bus.in_valid ? ACCUM : IDLE;
            ACCUM:   w_next = w_last ? DONE : ACCUM;
            DONE:    w_next = bus.out_ready ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_c     <= '0;
            r_i     <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && bus.in_valid) begin
                r_a <= bus.a;
                r_b <= bus.b;
                r_s <= '0;
                r_c <= '0;
                r_i <= '0;
            end else if (r_state == ACCUM) begin
                // 3:2 compression of the running rows with this step's partial product
                r_s <= r_s ^ r_c ^ w_pp;
                r_c <= ((r_s & r_c) | (r_s & w_pp) | (r_c & w_pp)) << 1;
                r_i <= r_i + IW'(1);
            end
        end
    end
endmodule

// File: tb/tb_csa_mul_seq.sv
// tb_csa_mul_seq: directed WIDTH=8 scenarios plus random pairs at WIDTH 4/8/16
// checked against a plain a*b reference.
`define RAND_RUN(IFC, W) \
    for (int n = 0; n < NOPS; n++) begin \
        ra = $urandom_range(0, (1 << W) - 1); \
        rb = $urandom_range(0, (1 << W) - 1); \
        IFC.a = ra[W-1:0]; \
        IFC.b = rb[W-1:0]; \
        IFC.out_ready = 1'b0; \
        IFC.in_valid = 1'b1; \
        chk("rand_in_ready", {63'd0, IFC.in_ready}, 64'd1); \
        tick(); \
        IFC.in_valid = 1'b0; \
        k = 0; \
        while (!(IFC.out_valid && IFC.out_ready) && k < 4 * W + 40) begin \
            tick(); \
            k++; \
            IFC.out_ready = $urandom_range(0, 2) != 0; \
        end \
        chk("rand_handshake", {63'd0, IFC.out_valid & IFC.out_ready}, 64'd1); \
        got = (64'(IFC.row_s) + 64'(IFC.row_c)) & ((64'd1 << (2 * W)) - 64'd1); \
        chk("rand_product", got, 64'(ra) * 64'(rb)); \
        tick(); \
        chk("rand_once", {63'd0, IFC.out_valid}, 64'd0); \
        IFC.out_ready = 1'b0; \
    end

module tb_csa_mul_seq;
    localparam int NOPS = 1000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_asrt = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    csa_mul_seq_if #(.WIDTH(8))  if8  ();
    csa_mul_seq_if #(.WIDTH(4))  if4  ();
    csa_mul_seq_if #(.WIDTH(16)) if16 ();

    csa_mul_seq #(.WIDTH(8))  u8  (.clk(clk), .rst_n(rst_n), .bus(if8));
    csa_mul_seq #(.WIDTH(4))  u4  (.clk(clk), .rst_n(rst_n), .bus(if4));
    csa_mul_seq #(.WIDTH(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(if16));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] sum8();
        logic [15:0] t;
        t = if8.row_s + if8.row_c;
        return {48'd0, t};
    endfunction

    task automatic start8(input logic [7:0] a, input logic [7:0] b);
        if8.a = a;
        if8.b = b;
        if8.in_valid = 1'b1;
        tick();
        if8.in_valid = 1'b0;
    endtask

    task automatic wait_valid8(input int lim);
        int k;
        k = 0;
        while (!if8.out_valid && k < lim) begin
            tick();
            k++;
        end
        chk("wait_out_valid", {63'd0, if8.out_valid}, 64'd1);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [63:0] got;
        logic [15:0] rs, rc;
        int k;
        {if8.in_valid, if8.a, if8.b, if8.out_ready} = '0;
        {if4.in_valid, if4.a, if4.b, if4.out_ready} = '0;
        {if16.in_valid, if16.a, if16.b, if16.out_ready} = '0;
        tick();
        tick();
        chk("reset_in_ready", {63'd0, if8.in_ready}, 64'd1);
        chk("reset_out_valid", {63'd0, if8.out_valid}, 64'd0);
        chk("reset_row_s", {48'd0, if8.row_s}, 64'd0);
        chk("reset_row_c", {48'd0, if8.row_c}, 64'd0);
        rst_n = 1'b1;
        // 3*4: exact latency of WIDTH cycles and a one-cycle result pulse
        if8.out_ready = 1'b1;
        start8(8'd3, 8'd4);
        repeat (7) tick();
        chk("lat7_out_valid", {63'd0, if8.out_valid}, 64'd0);
        tick();
        chk("lat8_out_valid", {63'd0, if8.out_valid}, 64'd1);
        chk("sum_3x4", sum8(), 64'd12);
        tick();
        chk("pulse_out_valid", {63'd0, if8.out_valid}, 64'd0);
        chk("pulse_in_ready", {63'd0, if8.in_ready}, 64'd1);
        start8(8'd255, 8'd255);
        wait_valid8(20);
        chk("sum_255x255", sum8(), 64'd65025);
        tick();
        start8(8'd0, 8'd200);
        wait_valid8(20);
        chk("zero_row_s", {48'd0, if8.row_s}, 64'd0);
        chk("zero_row_c", {48'd0, if8.row_c}, 64'd0);
        tick();
        // back-pressure: rows must hold while out_ready stays low
        if8.out_ready = 1'b0;
        start8(8'd100, 8'd77);
        wait_valid8(20);
        rs = if8.row_s;
        rc = if8.row_c;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("stall_out_valid", {63'd0, if8.out_valid}, 64'd1);
            chk("stall_row_s", {48'd0, if8.row_s}, {48'd0, rs});
            chk("stall_row_c", {48'd0, if8.row_c}, {48'd0, rc});
            chk("stall_in_ready", {63'd0, if8.in_ready}, 64'd0);
        end
        chk("sum_100x77", sum8(), 64'd7700);
        if8.out_ready = 1'b1;
        tick();
        chk("stall_consumed", {63'd0, if8.out_valid}, 64'd0);
        chk("stall_in_ready_after", {63'd0, if8.in_ready}, 64'd1);
        // new operands offered mid-operation must be ignored
        start8(8'd5, 8'd6);
        tick();
        tick();
        if8.a = 8'd7;
        if8.b = 8'd9;
        if8.in_valid = 1'b1;
        wait_valid8(20);
        chk("sum_5x6_ignore", sum8(), 64'd30);
        if8.in_valid = 1'b0;
        tick();
        chk("ignore_out_valid", {63'd0, if8.out_valid}, 64'd0);
        chk("ignore_in_ready", {63'd0, if8.in_ready}, 64'd1);
        // reset in the middle of accumulation drops the operation
        start8(8'd9, 8'd13);
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        chk("midrst_out_valid", {63'd0, if8.out_valid}, 64'd0);
        chk("midrst_row_s", {48'd0, if8.row_s}, 64'd0);
        chk("midrst_row_c", {48'd0, if8.row_c}, 64'd0);
        chk("midrst_in_ready", {63'd0, if8.in_ready}, 64'd1);
        rst_n = 1'b1;
        start8(8'd10, 8'd11);
        repeat (7) tick();
        chk("midrst_lat7", {63'd0, if8.out_valid}, 64'd0);
        tick();
        chk("midrst_lat8", {63'd0, if8.out_valid}, 64'd1);
        chk("sum_10x11", sum8(), 64'd110);
        tick();
        if8.out_ready = 1'b0;
        `RAND_RUN(if4, 4)
        `RAND_RUN(if8, 8)
        `RAND_RUN(if16, 16)
        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule

// File: doc/csa_mul_seq.md
CSA_MUL_SEQ -- requirements
Module: csa_mul_seq

Interface
REQ-001 SHALL have parameter: WIDTH, 8, unsigned operand width (WIDTH >= 2).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have port: in_valid  input  1  operand pair a/b present.
REQ-005 SHALL have port: in_ready  output  1  block can accept operands.
REQ-006 SHALL have port: a  input  WIDTH  multiplicand, unsigned.
REQ-007 SHALL have port: b  input  WIDTH  multiplier, unsigned.
REQ-008 SHALL have port: out_valid  output  1  row_s/row_c hold a finished result.
REQ-009 SHALL have port: out_ready  input  1  downstream final adder accepts rows.
REQ-010 SHALL have port: row_s  output  2*WIDTH  carry-save sum row, feeding the in1 operand of the team's final carry-propagate adder.
REQ-011 SHALL have port: row_c  output  2*WIDTH  carry-save carry row, feeding the in2 operand of that adder; that adder's czero is tied 0.

Function
REQ-012 SHALL implement an FSM with states IDLE, ACCUM, DONE.
REQ-013 SHALL drive in_ready = 1 only in IDLE and out_valid = 1 only in DONE.
REQ-014 SHALL, in IDLE on in_valid && in_ready, latch a and b, clear internal S and C to 0, clear step counter i to 0, and go to ACCUM.
REQ-015 SHALL, in each ACCUM cycle, form pp = b_latched[i] ? (a_latched << i) : 0, zero-extended to 2*WIDTH bits.
REQ-016 SHALL, in each ACCUM cycle, update S <= S ^ C ^ pp and C <= ((S & C) | (S & pp) | (C & pp)) << 1, both truncated to 2*WIDTH bits.
REQ-017 SHALL, in each ACCUM cycle, increment i, and transition to DONE on the cycle that processes i = WIDTH-1.
REQ-018 SHALL assert out_valid exactly WIDTH clock cycles after the accepting edge, independent of operand values (no zero-skip).
REQ-019 SHALL guarantee (row_s + row_c) mod 2^(2*WIDTH) == a * b for the accepted operands.
REQ-020 SHALL drive row_s = S and row_c = C, and hold both stable while out_valid = 1 and out_ready = 0.
REQ-021 SHALL, in DONE on out_ready = 1, complete the output handshake and return to IDLE; in_ready rises the following cycle (no same-cycle accept).
REQ-022 SHALL ignore a, b and in_valid outside IDLE; latched operands SHALL NOT change mid-operation.
REQ-023 SHALL ignore out_ready outside DONE.
REQ-024 SHALL use an i counter of $clog2(WIDTH)+1 bits, never wrapping within one operation.

Reset
REQ-025 SHALL, when rst_n = 0 at a rising edge, set state = IDLE, S = 0, C = 0, i = 0, latched a/b = 0.
REQ-026 SHALL drive after reset: in_ready = 1, out_valid = 0, row_s = 0, row_c = 0.
REQ-027 SHALL, on reset during ACCUM or DONE, discard the operation with no result emitted, and next accept operands in the first cycle with rst_n = 1.

Verification (WIDTH = 8 unless noted)
REQ-028 SHALL cover: a=3, b=4, out_ready=1 -> out_valid high 8 cycles after accept, row_s+row_c = 12, one-cycle out_valid pulse, in_ready = 1 next cycle.
REQ-029 SHALL cover: a=255, b=255 -> (row_s+row_c) mod 65536 = 65025; a=0, b=200 -> row_s = row_c = 0.
REQ-030 SHALL cover: out_ready held 0 for 5 cycles in DONE -> out_valid, row_s, row_c unchanged across all 5 cycles, in_ready = 0 throughout, and result consumed on cycle 6.
REQ-031 SHALL cover: in_valid=1 with a=7, b=9 driven during ACCUM of an operation with a=5, b=6 -> result sums to 30 and the 7/9 pair is not accepted.
REQ-032 SHALL cover: rst_n = 0 for 1 cycle at ACCUM step 4 -> out_valid = 0, rows = 0, in_ready = 1 after reset; next op a=10, b=11 sums to 110.
REQ-033 SHALL cover: 1000 random pairs at WIDTH = 4, 8, 16 with random out_ready stalls -> every sum matches a*b, and each result is delivered exactly once.
